// File: rtl/csr_file_pkg.sv
// CSR addresses, write masks, operation encodings and interrupt constants
// shared by the machine-mode CSR file and its counter sub-module.
package riscv_defines;

    localparam logic [11:0] CSR_ADDR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_ADDR_MIE           = 12'h304;
    localparam logic [11:0] CSR_ADDR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_ADDR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_ADDR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_ADDR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_ADDR_MIP           = 12'h344;
    localparam logic [11:0] CSR_ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_ADDR_MHARTID       = 12'hF14;

    localparam logic [31:0] CSR_MASK_MSTATUS       = 32'h0000_0088;
    localparam logic [31:0] CSR_MASK_MIE           = 32'h0000_0888;
    localparam logic [31:0] CSR_MASK_MIP           = 32'h0000_0000;
    localparam logic [31:0] CSR_MASK_MTVEC_VEC     = 32'hFFFF_FFFD;
    localparam logic [31:0] CSR_MASK_MTVEC_DIR     = 32'hFFFF_FFFC;
    localparam logic [31:0] CSR_MASK_MEPC          = 32'hFFFF_FFFC;
    localparam logic [31:0] CSR_MASK_FULL          = 32'hFFFF_FFFF;
    localparam logic [31:0] CSR_MASK_MCOUNTINHIBIT = 32'h0000_0005;
    localparam logic [31:0] CSR_MASK_NONE          = 32'h0000_0000;

    // MPP is hard-wired to machine mode; MIE/MPIE are the only live bits
    localparam logic [31:0] CSR_VALUE_MSTATUS      = 32'h0000_1800;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_mode_t;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MSI_BIT  = 3;
    localparam int MTI_BIT  = 7;
    localparam int MEI_BIT  = 11;

    localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
    localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
    localparam logic [4:0] IRQ_CODE_MEI = 5'd11;

    function automatic logic [31:0] csr_op_apply(input csr_mode_t op, input logic [31:0] old_val,
                                                 input logic [31:0] wdata, input logic [31:0] mask);
        logic [31:0] v;
        case (op)
            CSR_RW, CSR_RWI: v = wdata;
            CSR_RS, CSR_RSI: v = old_val | wdata;
            CSR_RC, CSR_RCI: v = old_val & ~wdata;
            default:         v = old_val;
        endcase
        return (old_val & ~mask) | (v & mask);
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with inhibit; a write to either 32-bit half
// replaces the increment for that cycle while the other half holds.
module csr_counter64
    import riscv_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_inhibit,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);

    logic [63:0] r_count;

    // Count register: write beats increment, wraps silently at 2^64
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 64'd0;
        end else if (i_wr_lo) begin
            r_count[31:0] <= i_wdata;
        end else if (i_wr_hi) begin
            r_count[63:32] <= i_wdata;
        end else if (i_inc && !i_inhibit) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap entry/return, latched interrupts, vectored mtvec.
// Define CSR_COUNTERS_EN to build mcycle/minstret/mcountinhibit.
module csr_file
    import riscv_defines::*;
#(
    parameter logic [31:0] HARTID      = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_valid,
    input  logic [11:0] csr_addr,
    input  logic [2:0]  csr_op,
    input  logic [31:0] csr_wdata,
    input  logic        csr_wr_en,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        retire,
    input  logic        trap_enter,
    input  logic        trap_return,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_tval,
    input  logic        irq_msip,
    input  logic        irq_mtip,
    input  logic        irq_meip,
    output logic        irq_pending,
    output logic [31:0] irq_cause,
    output logic [31:0] trap_target,
    output logic [31:0] mepc_o
);

    localparam logic [31:0] L_MTVEC_MASK = VECTORED_EN ? CSR_MASK_MTVEC_VEC : CSR_MASK_MTVEC_DIR;

    logic        r_mstatus_mie, r_mstatus_mpie;
    logic [31:0] r_mie, r_mip, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [31:0] w_mstatus, w_mip_next, w_rdata, w_mask, w_eff, w_pend;
    logic        w_known, w_illegal, w_wr;

`ifdef CSR_COUNTERS_EN
    logic [63:0] w_mcycle, w_minstret;
    logic [31:0] r_mcountinhibit;
`else
    logic        w_unused_retire;
    assign w_unused_retire = retire;
`endif

    // Assemble architectural views of mstatus and the next mip sample
    always_comb begin
        w_mstatus           = CSR_VALUE_MSTATUS;
        w_mstatus[MIE_BIT]  = r_mstatus_mie;
        w_mstatus[MPIE_BIT] = r_mstatus_mpie;
        w_mip_next          = 32'd0;
        w_mip_next[MSI_BIT] = irq_msip;
        w_mip_next[MTI_BIT] = irq_mtip;
        w_mip_next[MEI_BIT] = irq_meip;
    end

    // Address decode: read value, writable mask, implemented flag
    always_comb begin
        w_rdata = 32'd0;
        w_mask  = CSR_MASK_NONE;
        w_known = 1'b1;
        case (csr_addr)
            CSR_ADDR_MSTATUS:  begin w_rdata = w_mstatus;  w_mask = CSR_MASK_MSTATUS; end
            CSR_ADDR_MIE:      begin w_rdata = r_mie;      w_mask = CSR_MASK_MIE;     end
            CSR_ADDR_MTVEC:    begin w_rdata = r_mtvec;    w_mask = L_MTVEC_MASK;     end
            CSR_ADDR_MSCRATCH: begin w_rdata = r_mscratch; w_mask = CSR_MASK_FULL;    end
            CSR_ADDR_MEPC:     begin w_rdata = r_mepc;     w_mask = CSR_MASK_MEPC;    end
            CSR_ADDR_MCAUSE:   begin w_rdata = r_mcause;   w_mask = CSR_MASK_FULL;    end
            CSR_ADDR_MTVAL:    begin w_rdata = r_mtval;    w_mask = CSR_MASK_FULL;    end
            CSR_ADDR_MIP:      begin w_rdata = r_mip;      w_mask = CSR_MASK_MIP;     end
            CSR_ADDR_MHARTID:  begin w_rdata = HARTID;     w_mask = CSR_MASK_NONE;    end
`ifdef CSR_COUNTERS_EN
            CSR_ADDR_MCYCLE:    begin w_rdata = w_mcycle[31:0];    w_mask = CSR_MASK_FULL; end
            CSR_ADDR_MCYCLEH:   begin w_rdata = w_mcycle[63:32];   w_mask = CSR_MASK_FULL; end
            CSR_ADDR_MINSTRET:  begin w_rdata = w_minstret[31:0];  w_mask = CSR_MASK_FULL; end
            CSR_ADDR_MINSTRETH: begin w_rdata = w_minstret[63:32]; w_mask = CSR_MASK_FULL; end
            CSR_ADDR_MCOUNTINHIBIT: begin
                w_rdata = r_mcountinhibit;
                w_mask  = CSR_MASK_MCOUNTINHIBIT;
            end
`else
            CSR_ADDR_MCYCLE, CSR_ADDR_MCYCLEH, CSR_ADDR_MINSTRET,
            CSR_ADDR_MINSTRETH, CSR_ADDR_MCOUNTINHIBIT: w_known = 1'b1;
`endif
            default: w_known = 1'b0;
        endcase
    end

    assign w_eff       = csr_op_apply(csr_mode_t'(csr_op), w_rdata, csr_wdata, w_mask);
    assign w_illegal   = csr_valid & (~w_known | ((csr_addr[11:10] == 2'b11) & csr_wr_en));
    assign w_wr        = csr_valid & csr_wr_en & ~w_illegal & ~trap_enter & ~trap_return;
    assign csr_rdata   = w_rdata;
    assign csr_illegal = w_illegal;
    assign mepc_o      = r_mepc;

    // Trap vector: vectored mode offsets by 4*code for interrupts only
    always_comb begin
        if (r_mtvec[0] && trap_cause[31]) begin
            trap_target = {r_mtvec[31:2], 2'b00} + {25'd0, trap_cause[4:0], 2'b00};
        end else begin
            trap_target = {r_mtvec[31:2], 2'b00};
        end
    end

    // Interrupt arbitration, fixed priority MEI > MSI > MTI
    always_comb begin
        w_pend      = r_mie & r_mip;
        irq_pending = r_mstatus_mie & (|w_pend);
        irq_cause   = 32'd0;
        if (!r_mstatus_mie) begin
            irq_cause = 32'd0;
        end else if (w_pend[MEI_BIT]) begin
            irq_cause = {1'b1, 26'd0, IRQ_CODE_MEI};
        end else if (w_pend[MSI_BIT]) begin
            irq_cause = {1'b1, 26'd0, IRQ_CODE_MSI};
        end else if (w_pend[MTI_BIT]) begin
            irq_cause = {1'b1, 26'd0, IRQ_CODE_MTI};
        end else begin
            irq_cause = 32'd0;
        end
    end

    // Architectural state: trap entry beats mret beats CSR write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'd0;
            r_mip          <= 32'd0;
            r_mtvec        <= MTVEC_RESET & L_MTVEC_MASK;
            r_mscratch     <= 32'd0;
            r_mepc         <= 32'd0;
            r_mcause       <= 32'd0;
            r_mtval        <= 32'd0;
        end else begin
            r_mip <= w_mip_next;
            if (trap_enter) begin
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                r_mepc         <= trap_pc & CSR_MASK_MEPC;
                r_mcause       <= trap_cause;
                r_mtval        <= trap_tval;
            end else if (trap_return) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_wr) begin
                case (csr_addr)
                    CSR_ADDR_MSTATUS: begin
                        r_mstatus_mie  <= w_eff[MIE_BIT];
                        r_mstatus_mpie <= w_eff[MPIE_BIT];
                    end
                    CSR_ADDR_MIE:      r_mie      <= w_eff;
                    CSR_ADDR_MTVEC:    r_mtvec    <= w_eff;
                    CSR_ADDR_MSCRATCH: r_mscratch <= w_eff;
                    CSR_ADDR_MEPC:     r_mepc     <= w_eff;
                    CSR_ADDR_MCAUSE:   r_mcause   <= w_eff;
                    CSR_ADDR_MTVAL:    r_mtval    <= w_eff;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    // Counter inhibit register (bit0 = CY, bit2 = IR)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcountinhibit <= 32'd0;
        end else if (w_wr && (csr_addr == CSR_ADDR_MCOUNTINHIBIT)) begin
            r_mcountinhibit <= w_eff;
        end
    end

    csr_counter64 u_mcycle (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (1'b1),
        .i_inhibit (r_mcountinhibit[0]),
        .i_wr_lo   (w_wr && (csr_addr == CSR_ADDR_MCYCLE)),
        .i_wr_hi   (w_wr && (csr_addr == CSR_ADDR_MCYCLEH)),
        .i_wdata   (w_eff),
        .o_count   (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (retire),
        .i_inhibit (r_mcountinhibit[2]),
        .i_wr_lo   (w_wr && (csr_addr == CSR_ADDR_MINSTRET)),
        .i_wr_hi   (w_wr && (csr_addr == CSR_ADDR_MINSTRETH)),
        .i_wdata   (w_eff),
        .o_count   (w_minstret)
    );
`endif

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios followed by random
// traffic, all compared against a behavioural model of the CSR rules.
module tb_csr_file;

`ifdef CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, csr_valid, csr_wr_en, retire, trap_enter, trap_return;
    logic        irq_msip, irq_mtip, irq_meip;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic [31:0] csr_wdata, trap_pc, trap_cause, trap_tval;
    logic [31:0] csr_rdata, irq_cause, trap_target, mepc_o;
    logic        csr_illegal, irq_pending;

    always #5 clk = ~clk;

    csr_file dut (
        .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_wr_en(csr_wr_en), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .retire(retire), .trap_enter(trap_enter),
        .trap_return(trap_return), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
        .irq_pending(irq_pending), .irq_cause(irq_cause), .trap_target(trap_target),
        .mepc_o(mepc_o)
    );

    // reference model state
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip, m_inh;
    logic [63:0] m_cyc, m_ins;
    bit          m_ok = 1'b0;
    int          n_checks = 0, n_errors = 0;
    logic [31:0] obs_rdata, obs_cause, obs_target, obs_mepc;
    logic        obs_pending;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a, output bit known);
        logic [31:0] r;
        known = 1'b1;
        r = 32'd0;
        case (a)
            12'h300: r = m_mstatus;
            12'h304: r = m_mie;
            12'h305: r = m_mtvec;
            12'h340: r = m_mscratch;
            12'h341: r = m_mepc;
            12'h342: r = m_mcause;
            12'h343: r = m_mtval;
            12'h344: r = m_mip;
            12'hF14: r = 32'd0;
            12'h320: r = CNT_EN ? m_inh : 32'd0;
            12'hB00: r = CNT_EN ? m_cyc[31:0] : 32'd0;
            12'hB80: r = CNT_EN ? m_cyc[63:32] : 32'd0;
            12'hB02: r = CNT_EN ? m_ins[31:0] : 32'd0;
            12'hB82: r = CNT_EN ? m_ins[63:32] : 32'd0;
            default: known = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] m_irq_cause();
        logic [31:0] p;
        p = m_mie & m_mip;
        if (!m_mstatus[3]) return 32'd0;
        if (p[11]) return 32'h8000_000B;
        if (p[3])  return 32'h8000_0003;
        if (p[7])  return 32'h8000_0007;
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] base;
        base = m_mtvec & 32'hFFFF_FFFC;
        if (m_mtvec[0] && trap_cause[31]) return base + 32'd4 * {27'd0, trap_cause[4:0]};
        return base;
    endfunction

    function automatic bit m_illegal();
        bit k;
        logic [31:0] unused_v;
        unused_v = m_read(csr_addr, k);
        return csr_valid && (!k || (csr_addr[11:10] == 2'b11 && csr_wr_en));
    endfunction

    // advance the model across one rising edge using the inputs held at that edge
    task automatic model_edge();
        bit          k;
        logic [31:0] old, nv;
        logic [63:0] ncyc, nins;
        if (rst) begin
            m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
            m_mcause = 0; m_mtval = 0; m_mip = 0; m_inh = 0; m_cyc = 0; m_ins = 0;
            m_ok = 1'b1;
            return;
        end
        old  = m_read(csr_addr, k);
        ncyc = m_inh[0] ? m_cyc : m_cyc + 64'd1;
        nins = m_inh[2] ? m_ins : m_ins + {63'd0, retire};
        case (csr_op)
            3'b001, 3'b101: nv = csr_wdata;
            3'b010, 3'b110: nv = old | csr_wdata;
            default:        nv = old & ~csr_wdata;
        endcase
        if (trap_enter) begin
            m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
            m_mepc    = trap_pc & 32'hFFFF_FFFC;
            m_mcause  = trap_cause;
            m_mtval   = trap_tval;
        end else if (trap_return) begin
            m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end else if (csr_valid && csr_wr_en && !m_illegal()) begin
            case (csr_addr)
                12'h300: m_mstatus  = 32'h1800 | (nv & 32'h88);
                12'h304: m_mie      = nv & 32'h888;
                12'h305: m_mtvec    = nv & 32'hFFFF_FFFD;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
                12'h342: m_mcause   = nv;
                12'h343: m_mtval    = nv;
                12'h320: m_inh      = nv & 32'h5;
                12'hB00: ncyc = {m_cyc[63:32], nv};
                12'hB80: ncyc = {nv, m_cyc[31:0]};
                12'hB02: nins = {m_ins[63:32], nv};
                12'hB82: nins = {nv, m_ins[31:0]};
                default: ;
            endcase
        end
        m_cyc = ncyc;
        m_ins = nins;
        m_mip = {20'd0, irq_meip, 3'd0, irq_mtip, 3'd0, irq_msip, 3'd0};
    endtask

    // one clock cycle: sample outputs mid-cycle, then cross the edge
    task automatic cyc();
        bit          k;
        logic [31:0] v;
        #3;
        if (m_ok) begin
            v = m_read(csr_addr, k);
            check_eq("illegal", csr_illegal, m_illegal());
            if (csr_valid && k) check_eq($sformatf("rdata@%h", csr_addr), csr_rdata, v);
            check_eq("irq_pending", irq_pending, m_irq_cause() != 32'd0);
            check_eq("irq_cause", irq_cause, m_irq_cause());
            check_eq("trap_target", trap_target, m_target());
            check_eq("mepc_o", mepc_o, m_mepc);
        end
        obs_rdata   = csr_rdata;
        obs_pending = irq_pending;
        obs_cause   = irq_cause;
        obs_target  = trap_target;
        obs_mepc    = mepc_o;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        csr_valid = 1'b1; csr_addr = a; csr_op = 3'b010; csr_wdata = 32'd0; csr_wr_en = 1'b0;
        cyc();
        csr_valid = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
        csr_valid = 1'b1; csr_addr = a; csr_op = op; csr_wdata = d; csr_wr_en = 1'b1;
        cyc();
        csr_valid = 1'b0; csr_wr_en = 1'b0;
    endtask

    logic [11:0] addr_pool [16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'h344, 12'hF14, 12'h320, 12'hB00, 12'hB80,
                                    12'hB02, 12'hB82, 12'h301, 12'h7C0};
    logic [2:0]  op_pool [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        rst = 1'b1; csr_valid = 0; csr_addr = 0; csr_op = 3'b001; csr_wdata = 0; csr_wr_en = 0;
        retire = 0; trap_enter = 0; trap_return = 0; trap_pc = 0; trap_cause = 0; trap_tval = 0;
        irq_msip = 0; irq_mtip = 0; irq_meip = 0;
        #1;
        cyc(); cyc();
        rst = 1'b0;

        // reset values and free-running mcycle
        rd(12'hB00);  check_eq("rst_mcycle", obs_rdata, 32'd0);
        check_eq("rst_pending", obs_pending, 1'b0);
        check_eq("rst_mepc", obs_mepc, 32'd0);
        repeat (9) cyc();
        rd(12'hB00);  check_eq("mcycle_10", obs_rdata, CNT_EN ? 32'd10 : 32'd0);
        rd(12'h305);  check_eq("rst_mtvec", obs_rdata, 32'd0);
        rd(12'h300);  check_eq("rst_mstatus", obs_rdata, 32'h1800);

        // set-bits with and without write side effect
        wr(12'h300, 3'b010, 32'h8); check_eq("rs_old", obs_rdata, 32'h1800);
        rd(12'h300);  check_eq("rs_new", obs_rdata, 32'h1808);
        csr_valid = 1; csr_addr = 12'h300; csr_op = 3'b010; csr_wdata = 32'h80; csr_wr_en = 0;
        cyc(); csr_valid = 0;
        rd(12'h300);  check_eq("rs_nowr", obs_rdata, 32'h1808);

        // interrupt latching and priority
        wr(12'h304, 3'b001, 32'h888);
        irq_mtip = 1; cyc(); check_eq("irq_latency", obs_pending, 1'b0);
        cyc(); check_eq("irq_mti_pend", obs_pending, 1'b1);
        check_eq("irq_mti_cause", obs_cause, 32'h8000_0007);
        irq_meip = 1; cyc(); cyc();
        check_eq("irq_mei_cause", obs_cause, 32'h8000_000B);
        irq_mtip = 0; irq_meip = 0;

        // vectored trap entry
        wr(12'h305, 3'b001, 32'h1001);
        trap_enter = 1; trap_cause = 32'h8000_000B; trap_pc = 32'h203; trap_tval = 32'h77;
        cyc(); check_eq("vec_target", obs_target, 32'h102C);
        trap_enter = 0;
        rd(12'h300);  check_eq("trap_mstatus", obs_rdata, 32'h1880);
        check_eq("trap_mepc", obs_mepc, 32'h200);

        // trap entry beats mret and a CSR write in the same cycle
        wr(12'h340, 3'b001, 32'h1234);
        trap_enter = 1; trap_return = 1; trap_cause = 32'd2; trap_pc = 32'h100;
        csr_valid = 1; csr_addr = 12'h340; csr_op = 3'b001; csr_wdata = 32'hDEAD; csr_wr_en = 1;
        cyc();
        trap_enter = 0; trap_return = 0; csr_valid = 0; csr_wr_en = 0;
        rd(12'h340);  check_eq("prio_mscratch", obs_rdata, 32'h1234);
        rd(12'h300);  check_eq("prio_mstatus", obs_rdata, 32'h1800);
        rd(12'h342);  check_eq("prio_mcause", obs_rdata, 32'd2);
        check_eq("prio_mepc", obs_mepc, 32'h100);

        // counter carry, write-over-increment, 64-bit wrap
        wr(12'hB82, 3'b001, 32'd0);
        wr(12'hB02, 3'b001, 32'hFFFF_FFFF);
        retire = 1; rd(12'hB02); retire = 0;
        rd(12'hB02);  check_eq("minstret_lo", obs_rdata, 32'd0);
        rd(12'hB82);  check_eq("minstret_hi", obs_rdata, CNT_EN ? 32'd1 : 32'd0);
        wr(12'hB00, 3'b001, 32'd5);
        rd(12'hB00);  check_eq("mcycle_wr", obs_rdata, CNT_EN ? 32'd5 : 32'd0);
        wr(12'hB00, 3'b001, 32'hFFFF_FFFF);
        wr(12'hB80, 3'b001, 32'hFFFF_FFFF);
        rd(12'hB00);  check_eq("wrap_pre", obs_rdata, CNT_EN ? 32'hFFFF_FFFF : 32'd0);
        rd(12'hB80);  check_eq("wrap_hi", obs_rdata, 32'd0);
        rd(12'hF14);  check_eq("hartid", obs_rdata, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            csr_valid   = $urandom_range(0, 1);
            csr_addr    = addr_pool[$urandom_range(0, 15)];
            csr_op      = op_pool[$urandom_range(0, 5)];
            csr_wdata   = ($urandom_range(0, 3) == 0) ? 32'h0000_0888 : $urandom;
            csr_wr_en   = $urandom_range(0, 1);
            retire      = $urandom_range(0, 1);
            trap_enter  = ($urandom_range(0, 19) == 0);
            trap_return = ($urandom_range(0, 14) == 0);
            trap_pc     = $urandom;
            trap_cause  = {$urandom_range(0, 1) == 1, 26'd0, 5'($urandom_range(0, 31))};
            trap_tval   = $urandom;
            if ($urandom_range(0, 7) == 0) irq_msip = ~irq_msip;
            if ($urandom_range(0, 7) == 0) irq_mtip = ~irq_mtip;
            if ($urandom_range(0, 7) == 0) irq_meip = ~irq_meip;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
